user_obi_demux: RTL
===================

# user_obi_demux

Parametrised OBI demultiplexer for the user domain. It decodes each manager request against a table of up to `NumSbr` address rules and forwards it to the matching subordinate port. Requests that match no rule go to a built-in error subordinate. It tracks outstanding transactions so responses return in order, and it sits between the crossbar's user-domain port and the user peripherals.

## Interface
Parameters:
- `NumSbr`, default 2: number of external subordinate ports (≥1); the error subordinate is internal.
- `AddrWidth`, default 32: address width.
- `DataWidth`, default 32: data width; byte-enable width is `DataWidth/8`.
- `IdWidth`, default 1: OBI aid/rid width.
- `MaxTrans`, default 4: maximum outstanding transactions (≥1).
- `SbrBase`, default '0: `[NumSbr][AddrWidth]` base address per rule.
- `SbrSize`, default '0: `[NumSbr][AddrWidth]` size per rule; size 0 disables the rule.
- `ErrRdata`, default 32'hBADCAB1E: rdata returned by the error subordinate (zero-extended or truncated to `DataWidth`).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `mgr_req_i`, `mgr_we_i`  in  1  manager request, write enable.
- `mgr_addr_i`  in  AddrWidth  address.
- `mgr_be_i`  in  DataWidth/8  byte enables.
- `mgr_wdata_i`  in  DataWidth  write data.
- `mgr_aid_i`  in  IdWidth  transaction id.
- `mgr_gnt_o`, `mgr_rvalid_o`, `mgr_err_o`  out  1  grant, response valid, response error.
- `mgr_rdata_o`  out  DataWidth; `mgr_rid_o`  out  IdWidth.
- `sbr_req_o`, `sbr_we_o`  out  NumSbr  per-port request, write enable.
- `sbr_addr_o`  out  NumSbr×AddrWidth; `sbr_be_o`  out  NumSbr×DataWidth/8; `sbr_wdata_o`  out  NumSbr×DataWidth; `sbr_aid_o`  out  NumSbr×IdWidth.
- `sbr_gnt_i`, `sbr_rvalid_i`, `sbr_err_i`  in  NumSbr.
- `sbr_rdata_i`  in  NumSbr×DataWidth; `sbr_rid_i`  in  NumSbr×IdWidth.

## Operation
- **Decode.** Rule i matches when `SbrSize[i]!=0` and `SbrBase[i] <= addr < SbrBase[i]+SbrSize[i]`. The sum is computed in AddrWidth+1 bits, so no wrap occurs at the top of the address space. On overlapping rules the lowest index wins. If no rule matches, the target is the error subordinate (index `NumSbr`).
- **State.**
  - `cnt`: outstanding-transaction counter, $clog2(MaxTrans+1) bits.
  - `sel_q`: target of the outstanding transactions.
  - `err_pend_q`, `err_rid_q`: registered error-subordinate response.
- **Forward condition** `fwd = cnt==0 || (target==sel_q && cnt<MaxTrans)`.
  - When `fwd`: `sbr_req_o[target] = mgr_req_i`, and all other `sbr_req_o` bits are 0. Address, we, be, wdata and aid are broadcast to every port. `mgr_gnt_o` is the target's `sbr_gnt_i`, or 1 for the error subordinate.
  - When `!fwd`: all `sbr_req_o` are 0 and `mgr_gnt_o` is 0 (stall).
- **Handshake** (`mgr_req_i & mgr_gnt_o`): `sel_q <= target`, `cnt` increments.
- **Response.** `mgr_rvalid_o` = `sbr_rvalid_i[sel_q]` for `sel_q<NumSbr`, or `err_pend_q` for the error subordinate. rdata, err and rid are muxed the same way. An accepted response decrements `cnt`.
- **Simultaneous** handshake and response: `cnt` is unchanged.
- **Stray responses.** `rvalid` with `cnt==0` is not forwarded and `cnt` stays 0; this covers stale responses after a reset.
- **Error subordinate.** On an error-target handshake it sets `err_pend_q<=1` and `err_rid_q<=mgr_aid_i` for the next cycle. That response carries `mgr_err_o=1` and `mgr_rdata_o=ErrRdata`. With back-to-back error handshakes, `err_pend_q` stays 1 and one response is issued per cycle. Writes to the error subordinate also return `err=1`.
- **Response defaults.** With no response, `mgr_rdata_o`, `mgr_err_o` and `mgr_rid_o` are 0.
- **Manager contract.** OBI rules apply: req/addr/data stay stable until gnt. The block always accepts responses; there is no rready.

## Timing
- **Reset values** (`rst_i` high at a rising edge): `cnt=0`, `sel_q=0`, `err_pend_q=0`, `err_rid_q=0`. Consequently `mgr_rvalid_o=0`, `mgr_err_o=0`, `mgr_rdata_o=0`, `mgr_rid_o=0`, and all `sbr_req_o=0`.
  - `mgr_gnt_o` follows its combinational terms: with `mgr_req_i` low it is 0. Out of reset `cnt=0`, so any request is forwarded.
  - Reset mid-transfer discards all outstanding state.
- **Combinational paths.**
  - request → `sbr_req_o`;
  - `sbr_gnt_i` → `mgr_gnt_o`;
  - `sbr_rvalid_i`/`rdata`/`err`/`rid` → `mgr_*`.
  - External subordinates therefore add zero cycles in the demux.
- **Error-subordinate latency:** grant in the same cycle as req; response exactly 1 cycle after the handshake.
- **Target switch:** the earliest grant to a new target is the cycle after the last outstanding response of the old target is accepted. If that response and the new request fall in the same cycle, the request stalls until `cnt` reads 0 in the next cycle.
- **Throughput:** with `cnt==MaxTrans`, a new handshake is possible in the cycle after a response is accepted.

## Test plan
- **Decode:** NumSbr=2, Base={0x2000_0000,0x2000_1000}, Size=0x1000. Read 0x2000_0FFC → port 0. Read 0x2000_1000 → port 1. Read 0x2000_2000 → granted same cycle; next cycle rvalid=1, err=1, rdata=0xBADCAB1E, rid=aid.
- **Ordering stall:** issue 2 reads to port 0 while withholding rvalid, then a read to port 1. Port 1 sees no req and `mgr_gnt_o=0` until both port-0 responses return. Port 1 is granted the following cycle.
- **MaxTrans=4 on port 0:** four handshakes, then the fifth request stalls. One rvalid arrives → the fifth is granted next cycle and `cnt` returns to 4. A simultaneous grant and response keeps `cnt` constant.
- **Back-to-back error writes:** three unmapped writes on consecutive cycles, aid 0,1,0 → three consecutive rvalid cycles with err=1 and rid 0,1,0.
- **Reset mid-operation:** two outstanding on port 1, assert `rst_i` for 1 cycle → outputs at reset values. A late `sbr_rvalid_i[1]` afterwards is not forwarded. A new request to port 0 is granted immediately.
- **Disabled and overlapping rules:** Size[1]=0 → 0x2000_1000 goes to the error subordinate. Rules 0 and 1 both covering 0x2000_0000 → port 0 is selected.

Source files
------------

// File: rtl/user_obi_demux.sv
// user_obi_demux: OBI manager-to-N-subordinate demux with address decode,
// in-order outstanding tracking and a built-in error subordinate.
module user_obi_demux #(
   parameter int unsigned NumSbr    = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned IdWidth   = 1,
   parameter int unsigned MaxTrans  = 4,
   parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrBase = '0,
   parameter logic [NumSbr-1:0][AddrWidth-1:0] SbrSize = '0,
   parameter logic [31:0] ErrRdata = 32'hBADCAB1E
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  mgr_req_i,
   input  logic                                  mgr_we_i,
   input  logic [AddrWidth-1:0]                  mgr_addr_i,
   input  logic [DataWidth/8-1:0]                mgr_be_i,
   input  logic [DataWidth-1:0]                  mgr_wdata_i,
   input  logic [IdWidth-1:0]                    mgr_aid_i,
   output logic                                  mgr_gnt_o,
   output logic                                  mgr_rvalid_o,
   output logic                                  mgr_err_o,
   output logic [DataWidth-1:0]                  mgr_rdata_o,
   output logic [IdWidth-1:0]                    mgr_rid_o,
   output logic [NumSbr-1:0]                     sbr_req_o,
   output logic [NumSbr-1:0]                     sbr_we_o,
   output logic [NumSbr-1:0][AddrWidth-1:0]      sbr_addr_o,
   output logic [NumSbr-1:0][DataWidth/8-1:0]    sbr_be_o,
   output logic [NumSbr-1:0][DataWidth-1:0]      sbr_wdata_o,
   output logic [NumSbr-1:0][IdWidth-1:0]        sbr_aid_o,
   input  logic [NumSbr-1:0]                     sbr_gnt_i,
   input  logic [NumSbr-1:0]                     sbr_rvalid_i,
   input  logic [NumSbr-1:0]                     sbr_err_i,
   input  logic [NumSbr-1:0][DataWidth-1:0]      sbr_rdata_i,
   input  logic [NumSbr-1:0][IdWidth-1:0]        sbr_rid_i
);
   localparam int unsigned IdxW = $clog2(NumSbr + 1);
   localparam int unsigned CntW = $clog2(MaxTrans + 1);
   localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumSbr);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);
   localparam logic [DataWidth-1:0] ErrData = DataWidth'(ErrRdata);

   logic [IdxW-1:0] target;
   logic            fwd;
   logic            tgt_gnt;
   logic            hs;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdxW-1:0] sel_q, sel_d;
   logic            err_pend_q, err_pend_d;
   logic [IdWidth-1:0] err_rid_q, err_rid_d;

   // Descending scan so the lowest matching rule index wins.
   always_comb begin
      target = ErrIdx;
      for (int i = int'(NumSbr) - 1; i >= 0; i--) begin
         if ((SbrSize[i] != '0) &&
             ({1'b0, mgr_addr_i} >= {1'b0, SbrBase[i]}) &&
             ({1'b0, mgr_addr_i} <
              ({1'b0, SbrBase[i]} + {1'b0, SbrSize[i]}))) begin
            target = IdxW'(i);
         end
      end
   end

   always_comb begin
      fwd = (cnt_q == '0) || ((target == sel_q) && (cnt_q < CntMax));
      sbr_req_o = '0;
      tgt_gnt = (target == ErrIdx);
      for (int i = 0; i < int'(NumSbr); i++) begin
         if (target == IdxW'(i)) begin
            sbr_req_o[i] = mgr_req_i & fwd;
            tgt_gnt = sbr_gnt_i[i];
         end
      end
      mgr_gnt_o = mgr_req_i & fwd & tgt_gnt;
      hs = mgr_req_i & mgr_gnt_o;
   end

   assign sbr_we_o    = {NumSbr{mgr_we_i}};
   assign sbr_addr_o  = {NumSbr{mgr_addr_i}};
   assign sbr_be_o    = {NumSbr{mgr_be_i}};
   assign sbr_wdata_o = {NumSbr{mgr_wdata_i}};
   assign sbr_aid_o   = {NumSbr{mgr_aid_i}};

   // Responses only count while something is outstanding; strays are dropped.
   always_comb begin
      mgr_rvalid_o = 1'b0;
      mgr_err_o    = 1'b0;
      mgr_rdata_o  = '0;
      mgr_rid_o    = '0;
      if (cnt_q != '0) begin
         if ((sel_q == ErrIdx) && err_pend_q) begin
            mgr_rvalid_o = 1'b1;
            mgr_err_o    = 1'b1;
            mgr_rdata_o  = ErrData;
            mgr_rid_o    = err_rid_q;
         end
         for (int i = 0; i < int'(NumSbr); i++) begin
            if ((sel_q == IdxW'(i)) && sbr_rvalid_i[i]) begin
               mgr_rvalid_o = 1'b1;
               mgr_err_o    = sbr_err_i[i];
               mgr_rdata_o  = sbr_rdata_i[i];
               mgr_rid_o    = sbr_rid_i[i];
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (hs && !mgr_rvalid_o) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!hs && mgr_rvalid_o) begin
         cnt_d = cnt_q - CntW'(1);
      end
      sel_d      = hs ? target : sel_q;
      err_pend_d = hs && (target == ErrIdx);
      err_rid_d  = err_pend_d ? mgr_aid_i : err_rid_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         sel_q      <= '0;
         err_pend_q <= 1'b0;
         err_rid_q  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         err_pend_q <= err_pend_d;
         err_rid_q  <= err_rid_d;
      end
   end

endmodule
